// File: rtl/sprite_scheduler.sv
// Double-buffered sprite sequencer: game logic fills a shadow table, frame start latches it
// into a live table, and the live table is walked slot by slot over a valid/ready handshake.
module sprite_scheduler #(
  parameter int MAX_SPRITES = 16,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 720,
  parameter int NUM_FRAMES  = 512,
  localparam int SW = $clog2(MAX_SPRITES),
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int FW = $clog2(NUM_FRAMES)
) (
  input  logic          clk_pixel,
  input  logic          sys_rst_n,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_slot,
  input  logic          wr_enable,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [FW-1:0] wr_frame,
  input  logic          commit,
  input  logic          frame_start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_slot,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [FW-1:0] out_frame,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef struct packed {
    logic          en;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] frame;
  } desc_t;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [SW-1:0] r_idx;
  logic [SW-1:0] w_nextIdx;
  logic          r_commitPending;
  logic          r_done;
  logic          r_overrun;
  desc_t         r_shadow [MAX_SPRITES];
  desc_t         r_live   [MAX_SPRITES];

  desc_t w_cur;
  logic  w_advance;
  logic  w_lastSlot;
  logic  w_copy;

  assign w_cur      = r_live[r_idx];
  assign w_advance  = (r_state == SCAN) && (!w_cur.en || out_ready);
  assign w_lastSlot = (r_idx == SW'(MAX_SPRITES - 1));
  assign w_copy     = (r_state == IDLE) && frame_start && (r_commitPending || commit);

  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    case (r_state)
      IDLE: begin
        if (frame_start) begin
          w_nextState = SCAN;
          w_nextIdx   = '0;
        end
      end
      SCAN: begin
        if (w_advance) begin
          if (w_lastSlot) begin
            w_nextState = IDLE;
            w_nextIdx   = '0;
          end else begin
            w_nextIdx = r_idx + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (!sys_rst_n) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_commitPending <= 1'b0;
      r_done          <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_idx     <= w_nextIdx;
      r_done    <= w_advance && w_lastSlot;
      r_overrun <= (r_state == SCAN) && frame_start;
      // A commit that lands during a scan stays pending for the next frame start.
      if (w_copy) begin
        r_commitPending <= 1'b0;
      end else if (commit) begin
        r_commitPending <= 1'b1;
      end
    end
  end

  // The copy reads shadow before this edge's write, so a same-cycle write waits a frame.
  always_ff @(posedge clk_pixel) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < MAX_SPRITES; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
    end else begin
      if (w_copy) begin
        for (int i = 0; i < MAX_SPRITES; i++) begin
          r_live[i] <= r_shadow[i];
        end
      end
      if (wr_en) begin
        r_shadow[wr_slot] <= {wr_enable, wr_x, wr_y, wr_frame};
      end
    end
  end

  assign busy      = (r_state == SCAN);
  assign out_valid = busy && w_cur.en;
  assign out_slot  = busy ? r_idx : '0;
  assign out_x     = busy ? w_cur.x : '0;
  assign out_y     = busy ? w_cur.y : '0;
  assign out_frame = busy ? w_cur.frame : '0;
  assign done      = r_done;
  assign overrun   = r_overrun;

endmodule
